// File: rtl/sequential_mul_div.sv
// sequential_mul_div: radix-2 iterative signed/unsigned multiply, divide and remainder unit
module sequential_mul_div #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] leftOperand,
  input  logic [WIDTH-1:0] rightOperand,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             divByZero
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, RUN, FIX, ZERO} state_t;
  state_t state, nextState;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] acc, opB, opC, magL, magR, fixVal;
  logic [WIDTH:0] trial;
  logic isDiv, isRem, negRes, divIn, remIn, signedIn, signL, signR;
  always_comb begin
    divIn = op[2:1] == 2'b01 || op[2:1] == 2'b10;
    remIn = op[2:1] == 2'b10;
    signedIn = !op[0] && op != 3'd6;
    signL = signedIn && leftOperand[WIDTH-1];
    signR = signedIn && rightOperand[WIDTH-1];
    magL = signL ? -leftOperand : leftOperand;
    magR = signR ? -rightOperand : rightOperand;
    trial = {acc, opC[WIDTH-1]} - {1'b0, opB};
    fixVal = isDiv && !isRem ? opC : acc;
    nextState = state == IDLE ? (start ? (divIn && rightOperand == '0 ? ZERO : RUN) : IDLE) :
                state == RUN  ? (count == CW'(1) ? FIX : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= nextState;
  end
  // acc is the product accumulator for mul and the partial remainder for div; opC shifts
  // the multiplier out (mul) or the dividend out while the quotient shifts in (div).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
      result <= '0;
      divByZero <= 1'b0;
      count <= '0;
      acc <= '0;
      opB <= '0;
      opC <= '0;
      isDiv <= 1'b0;
      isRem <= 1'b0;
      negRes <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          busy <= 1'b1;
          divByZero <= 1'b0;
          isDiv <= divIn;
          isRem <= remIn;
          negRes <= remIn ? signL : signL ^ signR;
          acc <= '0;
          opB <= divIn ? magR : magL;
          opC <= divIn ? magL : magR;
          count <= CW'(WIDTH);
        end
        RUN: begin
          count <= count - CW'(1);
          if (isDiv) begin
            acc <= trial[WIDTH] ? {acc[WIDTH-2:0], opC[WIDTH-1]} : trial[WIDTH-1:0];
            opC <= {opC[WIDTH-2:0], !trial[WIDTH]};
          end else begin
            acc <= opC[0] ? acc + opB : acc;
            opB <= opB << 1;
            opC <= opC >> 1;
          end
        end
        FIX: begin
          result <= negRes ? -fixVal : fixVal;
          done <= 1'b1;
          busy <= 1'b0;
        end
        default: begin
          result <= '0;
          divByZero <= 1'b1;
          done <= 1'b1;
          busy <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_sequential_mul_div.sv
// tb_sequential_mul_div: scoreboarded random and directed checks of the mul/div unit at WIDTH 32 and 8
module tb_sequential_mul_div;
  logic clk = 1'b0, reset = 1'b1;
  logic start = 1'b0, start8 = 1'b0;
  logic [2:0] op = '0, op8 = '0;
  logic [31:0] l = '0, r = '0, result;
  logic [7:0] l8 = '0, r8 = '0, result8;
  logic busy, done, dbz, busy8, done8, dbz8;
  logic prevDone = 1'b0, prevDone8 = 1'b0;
  logic [32:0] q32[$];
  logic [8:0] q8[$];
  logic [32:0] exp32;
  logic [8:0] exp8;
  int checks = 0, fails = 0;

  sequential_mul_div #(.WIDTH(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .leftOperand(l), .rightOperand(r),
    .busy(busy), .done(done), .result(result), .divByZero(dbz)
  );
  sequential_mul_div #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start8), .op(op8), .leftOperand(l8), .rightOperand(r8),
    .busy(busy8), .done(done8), .result(result8), .divByZero(dbz8)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    checks++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, got, want);
    end
  endtask

  // Reference: plain integer arithmetic on sign-interpreted values, low w bits kept.
  function automatic logic [32:0] model(input int w, input logic [2:0] o, input logic [31:0] a,
                                        input logic [31:0] b);
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint sa = a[w-1] ? longint'(a) - longint'(64'd1 << w) : longint'(a);
    longint sb = b[w-1] ? longint'(b) - longint'(64'd1 << w) : longint'(b);
    longint unsigned res;
    if (o >= 3'd2 && o <= 3'd5 && b == 0) return {1'b1, 32'd0};
    case (o)
      3'd2: res = longint'(sa / sb);
      3'd3: res = longint'(a) / longint'(b);
      3'd4: res = longint'(sa % sb);
      3'd5: res = longint'(a) % longint'(b);
      default: res = longint'(a) * longint'(b);
    endcase
    return {1'b0, 32'(res & m)};
  endfunction

  always @(negedge clk) begin
    if (done === 1'b1) begin
      check("done32 pulse width", prevDone, 0);
      if (q32.size() == 0) check("unexpected done32", done, 0);
      else begin
        exp32 = q32.pop_front();
        check("result32", result, exp32[31:0]);
        check("divByZero32", dbz, exp32[32]);
      end
    end
    prevDone = done;
  end

  always @(negedge clk) begin
    if (done8 === 1'b1) begin
      check("done8 pulse width", prevDone8, 0);
      if (q8.size() == 0) check("unexpected done8", done8, 0);
      else begin
        exp8 = q8.pop_front();
        check("result8", result8, exp8[7:0]);
        check("divByZero8", dbz8, exp8[8]);
      end
    end
    prevDone8 = done8;
  end

  task automatic waitDone(output int lat, output int bc);
    lat = 0;
    bc = busy ? 1 : 0;
    while (done !== 1'b1 && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
      if (done !== 1'b1) bc += busy ? 1 : 0;
    end
    if (lat >= 100) check("done32 timeout", done, 1);
  endtask

  task automatic doOp(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                      output int lat, output int bc);
    start = 1'b1;
    op = o;
    l = a;
    r = b;
    q32.push_back(model(32, o, a, b));
    @(posedge clk);
    #1 start = 1'b0;
    waitDone(lat, bc);
  endtask

  task automatic dir(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                     input logic [31:0] want, input int wantLat, input logic wantDbz);
    int lat, bc;
    doOp(o, a, b, lat, bc);
    check("directed result", result, want);
    check("directed divByZero", dbz, wantDbz);
    check("directed latency", lat, wantLat);
    check("directed busy cycles", bc, wantLat);
    check("busy low with done", busy, 0);
  endtask

  task automatic doOp8(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b);
    logic [32:0] m;
    int lat = 0;
    int wantLat = (o >= 3'd2 && o <= 3'd5 && b == 0) ? 1 : 9;
    start8 = 1'b1;
    op8 = o;
    l8 = a;
    r8 = b;
    m = model(8, o, {24'd0, a}, {24'd0, b});
    q8.push_back({m[32], m[7:0]});
    @(posedge clk);
    #1 start8 = 1'b0;
    while (done8 !== 1'b1 && lat < 30) begin
      @(posedge clk);
      #1;
      lat++;
    end
    check("latency8", lat, wantLat);
  endtask

  initial begin
    int lat, bc;
    logic [7:0] corner[8] = '{8'h00, 8'h01, 8'h02, 8'h7f, 8'h80, 8'h81, 8'hfe, 8'hff};
    repeat (2) @(posedge clk);
    #1;
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset result", result, 0);
    check("reset divByZero", dbz, 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    dir(3'd1, 32'd1000, 32'd5, 32'd5000, 33, 0);
    dir(3'd0, 32'hfffffffe, 32'hfffffffe, 32'd4, 33, 0);
    dir(3'd0, 32'hc0000000, 32'd2, 32'h80000000, 33, 0);
    dir(3'd0, 32'hfffffffe, 32'd2, 32'hfffffffc, 33, 0);
    dir(3'd0, 32'h80000000, 32'hffffffff, 32'h80000000, 33, 0);
    dir(3'd2, 32'hfffffff9, 32'd2, 32'hfffffffd, 33, 0);
    dir(3'd4, 32'hfffffff9, 32'd2, 32'hffffffff, 33, 0);
    dir(3'd3, 32'hfffffffe, 32'd2, 32'h7fffffff, 33, 0);
    dir(3'd5, 32'd100, 32'd7, 32'd2, 33, 0);
    dir(3'd2, 32'h80000000, 32'hffffffff, 32'h80000000, 33, 0);
    dir(3'd4, 32'h80000000, 32'hffffffff, 32'd0, 33, 0);
    dir(3'd6, 32'hffffffff, 32'd3, 32'hfffffffd, 33, 0);
    dir(3'd3, 32'd5, 32'd0, 32'd0, 1, 1);
    dir(3'd1, 32'd3, 32'd3, 32'd9, 33, 0);
    for (int i = 0; i < 40; i++)
      doOp(3'($urandom_range(0, 7)), $urandom,
           $urandom_range(0, 5) == 0 ? 32'($urandom_range(0, 3)) : $urandom, lat, bc);
    // start held high and operands wiggled during the run must not disturb the result
    start = 1'b1;
    op = 3'd1;
    l = 32'd1234;
    r = 32'd567;
    q32.push_back(model(32, 3'd1, 32'd1234, 32'd567));
    @(posedge clk);
    repeat (10) begin
      #1;
      l = $urandom;
      r = $urandom;
      op = 3'($urandom_range(0, 7));
      @(posedge clk);
    end
    #1 start = 1'b0;
    waitDone(lat, bc);
    check("held-start result", result, 32'd699678);
    dir(3'd2, 32'hffffff9c, 32'd7, 32'hfffffff2, 33, 0);
    repeat (40) @(posedge clk);
    #1;
    start = 1'b1;
    op = 3'd2;
    l = 32'd999;
    r = 32'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #3 reset = 1'b1;
    #1;
    check("mid-run reset busy", busy, 0);
    check("mid-run reset done", done, 0);
    check("mid-run reset result", result, 0);
    check("mid-run reset divByZero", dbz, 0);
    #10 reset = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    check("no done after reset", busy, 0);
    for (int o = 0; o < 8; o++)
      for (int i = 0; i < 8; i++)
        for (int j = 0; j < 8; j++) doOp8(3'(o), corner[i], corner[j]);
    for (int i = 0; i < 300; i++)
      doOp8(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom));
    repeat (3) @(posedge clk);
    check("pending32", q32.size(), 0);
    check("pending8", q8.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
